segre_dtlb_refill: RTL and testbench

- Hardware refill engine answering data-TLB misses: takes the miss virtual address, walks a two-level in-memory page table, and returns the physical page plus a one-cycle write strobe so the TLB installs the translation.
- Sits between the DTLB miss output and the data memory arbiter.
- Replaces the fixed vpage+offset fake translation.

---
 rtl/segre_dtlb_refill_pkg.sv | 52 +++++
 rtl/segre_dtlb_refill_pte_check.sv | 70 +++++++
 rtl/segre_dtlb_refill.sv | 150 +++++++++++++++
 tb/tb_segre_dtlb_refill.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/segre_dtlb_refill_pkg.sv
// Shared types and constants for the DTLB refill walker: address geometry, PTE layout, walker states.
package segre_dtlb_refill_pkg;

    localparam int WORD_SIZE          = 32;
    localparam int PHYSICAL_ADDR_SIZE = 20;
    localparam int PAGE_OFFSET_BITS   = 12;
    localparam int PHYS_PAGE_BITS     = PHYSICAL_ADDR_SIZE - PAGE_OFFSET_BITS;
    localparam int VIRT_PAGE_BITS     = WORD_SIZE - PAGE_OFFSET_BITS;

    localparam int PTE_WORDS      = 1024;
    localparam int PTE_BYTES      = 4;
    localparam int VPN_SLICE_BITS = $clog2(PTE_WORDS);
    localparam int PTE_IDX_SHIFT  = $clog2(PTE_BYTES);
    localparam int PTE_PPN_BITS   = 22;

    localparam int PTE_V_BIT = 0;
    localparam int PTE_R_BIT = 1;
    localparam int PTE_W_BIT = 2;
    localparam int PTE_X_BIT = 3;

    typedef struct packed {
        logic [PTE_PPN_BITS-1:0] ppn;
        logic [5:0]              rsvd;
        logic                    x;
        logic                    w;
        logic                    r;
        logic                    v;
    } pte_t;

    typedef enum logic [2:0] {
        PTW_IDLE,
        PTW_L1_REQ,
        PTW_L1_WAIT,
        PTW_L2_REQ,
        PTW_L2_WAIT,
        PTW_RESP,
        PTW_FAULT
    } ptw_state_e;

    // Byte address of entry idx in the table that lives in physical page 'page'; wraps at the address width.
    function automatic logic [PHYSICAL_ADDR_SIZE-1:0] pte_addr(
        input logic [PHYS_PAGE_BITS-1:0] page,
        input logic [VPN_SLICE_BITS-1:0] idx
    );
        logic [PHYSICAL_ADDR_SIZE-1:0] base;
        logic [PHYSICAL_ADDR_SIZE-1:0] offs;
        base = {page, {PAGE_OFFSET_BITS{1'b0}}};
        offs = PHYSICAL_ADDR_SIZE'(idx) << PTE_IDX_SHIFT;
        return base + offs;
    endfunction

endpackage

// File: rtl/segre_dtlb_refill_pte_check.sv
// Combinational PTE decode and walk decision, shared by both table levels.
// L1 leaves (superpages) are accepted only when SEGRE_DTLB_REFILL_SUPERPAGE_EN is defined.
module segre_dtlb_refill_pte_check
    import segre_dtlb_refill_pkg::*;
(
    input  logic [WORD_SIZE-1:0]      pte_word,
    input  logic                      level1,
    input  logic                      is_store,
    input  logic [VPN_SLICE_BITS-1:0] vpn0,
    output logic                      descend,
    output logic                      leaf_ok,
    output logic                      fault,
    output logic [PHYS_PAGE_BITS-1:0] table_page,
    output logic [PHYS_PAGE_BITS-1:0] ppage
);

    pte_t pte;
    logic v, r, w, x;
    logic bad_enc;
    logic leaf;
    logic perm_ok;
    logic ppn_fits;

    assign pte = pte_t'(pte_word);
    assign v   = pte_word[PTE_V_BIT];
    assign r   = pte_word[PTE_R_BIT];
    assign w   = pte_word[PTE_W_BIT];
    assign x   = pte_word[PTE_X_BIT];

    // Write-only encodings are reserved and treated like an invalid entry.
    assign bad_enc  = !v || (w && !r);
    assign leaf     = r || x;
    assign perm_ok  = is_store ? w : r;
    assign ppn_fits = (pte.ppn[PTE_PPN_BITS-1:PHYS_PAGE_BITS] == '0);

    assign table_page = pte.ppn[PHYS_PAGE_BITS-1:0];

`ifdef SEGRE_DTLB_REFILL_SUPERPAGE_EN
    logic [PTE_PPN_BITS-1:0] sp_page;
    logic                    sp_aligned;
    assign sp_page    = {pte.ppn[PTE_PPN_BITS-1:VPN_SLICE_BITS], vpn0};
    assign sp_aligned = (pte.ppn[VPN_SLICE_BITS-1:0] == '0);
`endif

    always_comb begin
        descend = 1'b0;
        leaf_ok = 1'b0;
        ppage   = pte.ppn[PHYS_PAGE_BITS-1:0];
        if (level1) begin
            descend = !bad_enc && !leaf;
`ifdef SEGRE_DTLB_REFILL_SUPERPAGE_EN
            leaf_ok = !bad_enc && leaf && perm_ok && sp_aligned;
            ppage   = sp_page[PHYS_PAGE_BITS-1:0];
`endif
        end else begin
            leaf_ok = !bad_enc && leaf && perm_ok && ppn_fits;
        end
    end

    assign fault = !descend && !leaf_ok;

`ifdef SEGRE_DTLB_REFILL_SUPERPAGE_EN
    logic unused_bits;
    assign unused_bits = ^{pte.rsvd};
`else
    logic unused_bits;
    assign unused_bits = ^{pte.rsvd, vpn0, x};
`endif

endmodule

// File: rtl/segre_dtlb_refill.sv
// Data-TLB refill engine: two-level page-table walk on a miss, one-cycle refill or fault strobe.
// Superpage leaves at level 1 are honoured when SEGRE_DTLB_REFILL_SUPERPAGE_EN is defined.
module segre_dtlb_refill
    import segre_dtlb_refill_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [PHYS_PAGE_BITS-1:0]     ptbr_i,
    input  logic                          miss_valid_i,
    input  logic [WORD_SIZE-1:0]          miss_vaddr_i,
    input  logic                          miss_store_i,
    output logic                          miss_ready_o,
    output logic                          mem_req_o,
    output logic [PHYSICAL_ADDR_SIZE-1:0] mem_addr_o,
    input  logic                          mem_gnt_i,
    input  logic                          mem_rvalid_i,
    input  logic [WORD_SIZE-1:0]          mem_rdata_i,
    output logic                          refill_valid_o,
    output logic [VIRT_PAGE_BITS-1:0]     refill_vpage_o,
    output logic [PHYS_PAGE_BITS-1:0]     refill_ppage_o,
    output logic                          fault_o,
    output logic                          busy_o,
    input  logic                          flush_i
);

    ptw_state_e                    state_reg;
    logic [VIRT_PAGE_BITS-1:0]     vpage_reg;
    logic                          store_reg;
    logic                          abort_reg;
    logic [PHYS_PAGE_BITS-1:0]     ppage_reg;
    logic                          mem_req_reg;
    logic [PHYSICAL_ADDR_SIZE-1:0] mem_addr_reg;
    logic                          refill_valid_reg;
    logic [VIRT_PAGE_BITS-1:0]     refill_vpage_reg;
    logic [PHYS_PAGE_BITS-1:0]     refill_ppage_reg;
    logic                          fault_reg;

    logic                          chk_descend;
    logic                          chk_leaf_ok;
    logic                          chk_fault;
    logic [PHYS_PAGE_BITS-1:0]     chk_table_page;
    logic [PHYS_PAGE_BITS-1:0]     chk_ppage;

    segre_dtlb_refill_pte_check u_pte_check (
        .pte_word   (mem_rdata_i),
        .level1     (state_reg == PTW_L1_WAIT),
        .is_store   (store_reg),
        .vpn0       (vpage_reg[VPN_SLICE_BITS-1:0]),
        .descend    (chk_descend),
        .leaf_ok    (chk_leaf_ok),
        .fault      (chk_fault),
        .table_page (chk_table_page),
        .ppage      (chk_ppage)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg        <= PTW_IDLE;
            vpage_reg        <= '0;
            store_reg        <= 1'b0;
            abort_reg        <= 1'b0;
            ppage_reg        <= '0;
            mem_req_reg      <= 1'b0;
            mem_addr_reg     <= '0;
            refill_valid_reg <= 1'b0;
            refill_vpage_reg <= '0;
            refill_ppage_reg <= '0;
            fault_reg        <= 1'b0;
        end else begin
            refill_valid_reg <= 1'b0;
            fault_reg        <= 1'b0;
            unique case (state_reg)
                PTW_IDLE: begin
                    if (miss_valid_i) begin
                        vpage_reg    <= miss_vaddr_i[WORD_SIZE-1:PAGE_OFFSET_BITS];
                        store_reg    <= miss_store_i;
                        abort_reg    <= 1'b0;
                        mem_req_reg  <= 1'b1;
                        mem_addr_reg <= pte_addr(ptbr_i,
                                                 miss_vaddr_i[WORD_SIZE-1 -: VPN_SLICE_BITS]);
                        state_reg    <= PTW_L1_REQ;
                    end
                end
                PTW_L1_REQ, PTW_L2_REQ: begin
                    // A grant wins over a same-cycle flush: the read is in flight and must be drained.
                    if (mem_gnt_i) begin
                        mem_req_reg <= 1'b0;
                        abort_reg   <= flush_i;
                        state_reg   <= (state_reg == PTW_L1_REQ) ? PTW_L1_WAIT : PTW_L2_WAIT;
                    end else if (flush_i) begin
                        mem_req_reg <= 1'b0;
                        state_reg   <= PTW_IDLE;
                    end
                end
                PTW_L1_WAIT, PTW_L2_WAIT: begin
                    if (flush_i) begin
                        abort_reg <= 1'b1;
                    end
                    if (mem_rvalid_i) begin
                        abort_reg <= 1'b0;
                        if (abort_reg || flush_i) begin
                            state_reg <= PTW_IDLE;
                        end else if (chk_descend) begin
                            mem_req_reg  <= 1'b1;
                            mem_addr_reg <= pte_addr(chk_table_page,
                                                     vpage_reg[VPN_SLICE_BITS-1:0]);
                            state_reg    <= PTW_L2_REQ;
                        end else if (chk_leaf_ok) begin
                            ppage_reg <= chk_ppage;
                            state_reg <= PTW_RESP;
                        end else begin
                            state_reg <= PTW_FAULT;
                        end
                    end
                end
                PTW_RESP: begin
                    if (!flush_i) begin
                        refill_valid_reg <= 1'b1;
                        refill_vpage_reg <= vpage_reg;
                        refill_ppage_reg <= ppage_reg;
                    end
                    state_reg <= PTW_IDLE;
                end
                PTW_FAULT: begin
                    if (!flush_i) begin
                        fault_reg        <= 1'b1;
                        refill_vpage_reg <= vpage_reg;
                    end
                    state_reg <= PTW_IDLE;
                end
                default: begin
                    state_reg <= PTW_IDLE;
                end
            endcase
        end
    end

    assign miss_ready_o   = (state_reg == PTW_IDLE);
    assign busy_o         = (state_reg != PTW_IDLE);
    assign mem_req_o      = mem_req_reg;
    assign mem_addr_o     = mem_addr_reg;
    assign refill_valid_o = refill_valid_reg;
    assign refill_vpage_o = refill_vpage_reg;
    assign refill_ppage_o = refill_ppage_reg;
    assign fault_o        = fault_reg;

    logic unused_bits;
    assign unused_bits = ^{miss_vaddr_i[PAGE_OFFSET_BITS-1:0], chk_fault};

endmodule

// File: tb/tb_segre_dtlb_refill.sv
// Bench for segre_dtlb_refill: table-driven walks against a small memory model plus flush/reset sequences.
module tb_segre_dtlb_refill;
    import segre_dtlb_refill_pkg::*;

    localparam int K_REFILL = 1;
    localparam int K_FAULT  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ptbr = '0;
    logic        miss_valid = 1'b0;
    logic [31:0] miss_vaddr = '0;
    logic        miss_store = 1'b0;
    logic        miss_ready;
    logic        mem_req;
    logic [19:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        refill_valid;
    logic [19:0] refill_vpage;
    logic [7:0]  refill_ppage;
    logic        fault;
    logic        busy;
    logic        flush = 1'b0;

    segre_dtlb_refill dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ptbr_i         (ptbr),
        .miss_valid_i   (miss_valid),
        .miss_vaddr_i   (miss_vaddr),
        .miss_store_i   (miss_store),
        .miss_ready_o   (miss_ready),
        .mem_req_o      (mem_req),
        .mem_addr_o     (mem_addr),
        .mem_gnt_i      (mem_gnt),
        .mem_rvalid_i   (mem_rvalid),
        .mem_rdata_i    (mem_rdata),
        .refill_valid_o (refill_valid),
        .refill_vpage_o (refill_vpage),
        .refill_ppage_o (refill_ppage),
        .fault_o        (fault),
        .busy_o         (busy),
        .flush_i        (flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ptbr;
        logic [31:0] vaddr;
        logic        store;
        logic [31:0] pte1;
        logic [31:0] pte2;
        int          nreads;
        int          kind;
        logic [19:0] vpage;
        logic [7:0]  ppage;
        logic [19:0] addr1;
        logic [19:0] addr2;
        int          stall1;
        int          rv1;
        int          rv2;
        int          lat;
    } vec_t;

    typedef struct {
        int          kind;
        logic [19:0] vpage;
        logic [7:0]  ppage;
        int          lat;
    } exp_t;

    vec_t        vecs[13];
    exp_t        exp_q[$];
    logic [31:0] pte_q[$];
    logic [19:0] addr_q[$];
    int          rv_q[$];

    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          accept_cyc = 0;
    int          gnt_count = 0;
    int          result_count = 0;
    int          gnt_stall = 0;
    logic        rd_pending = 1'b0;
    int          rd_wait = 0;
    logic [31:0] rd_data = '0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Memory model and output monitor, both sampling on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        if (rst) begin
            rd_pending = 1'b0;
        end else begin
            if (miss_valid && miss_ready) accept_cyc = cyc;
            if (refill_valid || fault) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, refill_valid, fault}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", refill_valid ? K_REFILL : K_FAULT, e.kind);
                    check("pulse_exclusive", {31'd0, refill_valid & fault}, 32'd0);
                    check("pulse_vpage", refill_vpage, e.vpage);
                    if (e.kind == K_REFILL) check("pulse_ppage", refill_ppage, e.ppage);
                    check("pulse_latency", cyc - accept_cyc, e.lat);
                    check("ready_at_pulse", miss_ready, 1);
                    result_count++;
                end
            end
            if (rd_pending) begin
                if (rd_wait == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rd_data;
                    rd_pending = 1'b0;
                end else begin
                    rd_wait--;
                end
            end else if (mem_req) begin
                if (addr_q.size() == 0) begin
                    check("unexpected_req", mem_req, 0);
                end else if (gnt_stall > 0) begin
                    gnt_stall--;
                    check("stall_addr", mem_addr, addr_q[0]);
                end else begin
                    mem_gnt = 1'b1;
                    check("req_addr", mem_addr, addr_q.pop_front());
                    rd_data    = pte_q.pop_front();
                    rd_wait    = rv_q.pop_front();
                    rd_pending = 1'b1;
                    gnt_count++;
                end
            end
        end
    end

    task automatic start_miss(input logic [7:0] p, input logic [31:0] va, input logic st);
        @(posedge clk);
        #1;
        ptbr       = p;
        miss_vaddr = va;
        miss_store = st;
        miss_valid = 1'b1;
        @(posedge clk);
        #1;
        miss_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   base_g;
        int   base_r;
        int   t;
        exp_t e;
        pte_q.push_back(v.pte1);
        addr_q.push_back(v.addr1);
        rv_q.push_back(v.rv1);
        if (v.nreads == 2) begin
            pte_q.push_back(v.pte2);
            addr_q.push_back(v.addr2);
            rv_q.push_back(v.rv2);
        end
        gnt_stall = v.stall1;
        e.kind  = v.kind;
        e.vpage = v.vpage;
        e.ppage = v.ppage;
        e.lat   = v.lat;
        exp_q.push_back(e);
        base_g = gnt_count;
        base_r = result_count;
        start_miss(v.ptbr, v.vaddr, v.store);
        t = 0;
        while (result_count == base_r && t < 100) begin
            @(negedge clk);
            #2;
            t++;
        end
        check("walk_done", result_count - base_r, 1);
        check("walk_reads", gnt_count - base_g, v.nreads);
        check("walk_addr_drain", addr_q.size(), 0);
        exp_q.delete();
        pte_q.delete();
        addr_q.delete();
        rv_q.delete();
        @(negedge clk);
        #2;
        check("idle_after_walk", miss_ready, 1);
        $display("vec %0d: vaddr=0x%08h store=%0b kind=%0d reads=%0d cycles=%0d", idx, v.vaddr,
                 v.store, v.kind, gnt_count - base_g, t);
    endtask

    initial begin
        int base_g;
        int t;

        vecs[0]  = '{8'h01, 32'h00403ABC, 1'b0, 32'h00000801, 32'h00016807, 2, K_REFILL, 20'h00403, 8'h5A, 20'h01004, 20'h0200C, 0, 0, 0, 6};
        vecs[1]  = '{8'h01, 32'h00403ABC, 1'b1, 32'h00000801, 32'h00016803, 2, K_FAULT,  20'h00403, 8'h00, 20'h01004, 20'h0200C, 0, 0, 0, 6};
        vecs[2]  = '{8'h01, 32'h00403ABC, 1'b0, 32'h00000000, 32'h00000000, 1, K_FAULT,  20'h00403, 8'h00, 20'h01004, 20'h00000, 0, 0, 0, 4};
        vecs[3]  = '{8'h01, 32'h00403ABC, 1'b0, 32'h00000801, 32'h00016807, 2, K_REFILL, 20'h00403, 8'h5A, 20'h01004, 20'h0200C, 5, 0, 0, 11};
        vecs[4]  = '{8'h01, 32'h00403ABC, 1'b1, 32'h00000801, 32'h00016807, 2, K_REFILL, 20'h00403, 8'h5A, 20'h01004, 20'h0200C, 0, 0, 0, 6};
        vecs[5]  = '{8'hFF, 32'hFFFFF000, 1'b0, 32'h0003F801, 32'h0000CC03, 2, K_REFILL, 20'hFFFFF, 8'h33, 20'hFFFFC, 20'hFEFFC, 0, 0, 0, 6};
        vecs[6]  = '{8'h01, 32'h00403ABC, 1'b0, 32'h00000801, 32'h00056807, 2, K_FAULT,  20'h00403, 8'h00, 20'h01004, 20'h0200C, 0, 0, 0, 6};
        vecs[7]  = '{8'h01, 32'h00403ABC, 1'b0, 32'h00000801, 32'h00016801, 2, K_FAULT,  20'h00403, 8'h00, 20'h01004, 20'h0200C, 0, 0, 0, 6};
        vecs[8]  = '{8'h01, 32'h00403ABC, 1'b0, 32'h00000805, 32'h00000000, 1, K_FAULT,  20'h00403, 8'h00, 20'h01004, 20'h00000, 0, 0, 0, 4};
        vecs[9]  = '{8'h01, 32'h00403ABC, 1'b0, 32'h00000801, 32'h00016809, 2, K_FAULT,  20'h00403, 8'h00, 20'h01004, 20'h0200C, 0, 0, 0, 6};
        vecs[10] = '{8'h01, 32'h00403ABC, 1'b0, 32'h00100C03, 32'h00000000, 1, K_FAULT,  20'h00403, 8'h00, 20'h01004, 20'h00000, 0, 0, 0, 4};
`ifdef SEGRE_DTLB_REFILL_SUPERPAGE_EN
        vecs[11] = '{8'h01, 32'h00403ABC, 1'b0, 32'h00100003, 32'h00000000, 1, K_REFILL, 20'h00403, 8'h03, 20'h01004, 20'h00000, 0, 0, 0, 4};
`else
        vecs[11] = '{8'h01, 32'h00403ABC, 1'b0, 32'h00100003, 32'h00000000, 1, K_FAULT,  20'h00403, 8'h00, 20'h01004, 20'h00000, 0, 0, 0, 4};
`endif
        vecs[12] = '{8'h01, 32'h00403ABC, 1'b0, 32'h00000801, 32'h00016807, 2, K_REFILL, 20'h00403, 8'h5A, 20'h01004, 20'h0200C, 0, 2, 1, 9};

        // Reset state
        #12;
        check("rst_ready", miss_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_refill", refill_valid, 0);
        check("rst_fault", fault, 0);
        check("rst_vpage", refill_vpage, 0);
        check("rst_ppage", refill_ppage, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        $display("reset released");

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], i);
        end

        // Flush while the L2 read is outstanding; rvalid arrives three cycles later.
        base_g = gnt_count;
        pte_q.push_back(32'h00000801); addr_q.push_back(20'h01004); rv_q.push_back(0);
        pte_q.push_back(32'h00016807); addr_q.push_back(20'h0200C); rv_q.push_back(3);
        gnt_stall = 0;
        start_miss(8'h01, 32'h00403ABC, 1'b0);
        t = 0;
        while (gnt_count < base_g + 2 && t < 50) begin
            @(negedge clk);
            #2;
            t++;
        end
        check("flush_l2_granted", gnt_count - base_g, 2);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        t = 0;
        while (!mem_rvalid && t < 20) begin
            @(negedge clk);
            #2;
            t++;
        end
        check("flush_rvalid_seen", mem_rvalid, 1);
        check("flush_wait_for_data", miss_ready, 0);
        @(negedge clk);
        #2;
        check("flush_ready_after", miss_ready, 1);
        check("flush_busy_after", busy, 0);
        $display("flush in L2_WAIT: drained after %0d cycles", t);
        run_vec(vecs[0], 100);

        // Asynchronous reset while the L1 read is outstanding.
        base_g = gnt_count;
        pte_q.push_back(32'h00000801); addr_q.push_back(20'h01004); rv_q.push_back(5);
        gnt_stall = 0;
        start_miss(8'h01, 32'h00403ABC, 1'b0);
        t = 0;
        while (gnt_count < base_g + 1 && t < 50) begin
            @(negedge clk);
            #2;
            t++;
        end
        check("rstmid_l1_granted", gnt_count - base_g, 1);
        @(posedge clk);
        #1;
        check("rstmid_busy_before", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_busy", busy, 0);
        check("rstmid_ready", miss_ready, 1);
        check("rstmid_req", mem_req, 0);
        check("rstmid_refill", refill_valid, 0);
        check("rstmid_fault", fault, 0);
        pte_q.delete();
        addr_q.delete();
        rv_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        $display("reset mid L1_WAIT: state cleared");
        run_vec(vecs[0], 101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected finish");
        $fatal(1);
    end

endmodule
